// File: rtl/rr_arbiter8_pkg.sv
// -----------------------------------------------------------------------------
// rr_arbiter8_pkg
//   Shared constants and FSM state encoding for the 8-way round-robin arbiter.
//   NREQ  : number of requesters (fixed at 8)
//   IDX_W : width of the binary grant index (3)
// -----------------------------------------------------------------------------
package rr_arbiter8_pkg;

  localparam int unsigned NREQ  = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/onehot_enc8.sv
// -----------------------------------------------------------------------------
// onehot_enc8
//   Combinational 8-bit one-hot to 3-bit binary index encoder.
//   A zero vector or any vector that is not exactly one-hot encodes to 0.
//
// Ports
//   onehot  in  [7:0]  one-hot input vector
//   idx     out [2:0]  binary index of the set bit
// -----------------------------------------------------------------------------
module onehot_enc8
  import rr_arbiter8_pkg::*;
(
  input  logic [NREQ-1:0]  onehot,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    idx = '0;
    case (onehot)
      8'b0000_0001: idx = 3'd0;
      8'b0000_0010: idx = 3'd1;
      8'b0000_0100: idx = 3'd2;
      8'b0000_1000: idx = 3'd3;
      8'b0001_0000: idx = 3'd4;
      8'b0010_0000: idx = 3'd5;
      8'b0100_0000: idx = 3'd6;
      8'b1000_0000: idx = 3'd7;
      default:      idx = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter8.sv
// -----------------------------------------------------------------------------
// rr_arbiter8
//   Round-robin arbiter sharing one resource between 8 requesters. A grant is
//   issued one cycle after a request is seen in IDLE, held until the owner
//   signals done, withdraws its request, or en drops, and is always followed
//   by a single RELEASE cycle (dead gap) before the next grant. The search
//   pointer moves to one past the last owner on every release.
//
//   Optional build macro RR_ARBITER8_TIMEOUT_EN adds a hold counter that
//   forces a release after MAX_HOLD grant cycles, plus a timeout output that
//   pulses during that RELEASE cycle.
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   en       in   enable; 0 forces release and blocks new grants
//   req      in   [7:0] request vector, bit i = requester i (level-sensitive)
//   done     in   current owner finished; only looked at while granted
//   gnt      out  [7:0] registered one-hot grant
//   gnt_idx  out  [2:0] registered binary index of the owner
//   gnt_vld  out  a grant is active
//   busy     out  FSM not in IDLE
//   timeout  out  (RR_ARBITER8_TIMEOUT_EN only) forced-release pulse
// -----------------------------------------------------------------------------
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [NREQ-1:0]  req,
  input  logic             done,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             busy
`ifdef RR_ARBITER8_TIMEOUT_EN
  ,
  output logic             timeout
`endif
);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;

  // Winner selection
  logic [NREQ-1:0]   rot_req;
  logic [NREQ-1:0]   rot_low;
  logic [IDX_W-1:0]  rot_idx;
  logic [IDX_W-1:0]  win_idx;
  logic [NREQ-1:0]   win_onehot;

  // Control
  logic              start;
  logic              rel_normal;
  logic              hold_expired;
  logic              rel;

  // Next values for the registered outputs
  logic [NREQ-1:0]   gnt_d;
  logic [IDX_W-1:0]  idx_d;
  logic              vld_d;
  logic              busy_d;

  // ---------------------------------------------------------------------------
  // Round-robin pick: rotate req so that bit ptr lands at position 0, isolate
  // the lowest set bit, encode it, then add ptr back to undo the rotation.
  // ---------------------------------------------------------------------------
  always_comb begin
    rot_req = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      rot_req[i] = req[ptr_q + IDX_W'(i)];
    end
  end

  assign rot_low = rot_req & (~rot_req + NREQ'(1));

  onehot_enc8 u_enc (
    .onehot (rot_low),
    .idx    (rot_idx)
  );

  assign win_idx    = rot_idx + ptr_q;
  assign win_onehot = NREQ'(1) << win_idx;

  assign start      = en & (|req);
  assign rel_normal = done | ~req[gnt_idx] | ~en;
  assign rel        = rel_normal | hold_expired;

  // ---------------------------------------------------------------------------
  // Optional grant-length limit
  // ---------------------------------------------------------------------------
`ifdef RR_ARBITER8_TIMEOUT_EN
  localparam int unsigned HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              timeout_d;

  // IDLE always precedes GRANT, so the count is already 0 on the first
  // GRANT cycle; it only runs while granted.
  assign hold_d       = (state_q == GRANT) ? hold_q + 1'b1 : '0;
  assign hold_expired = (state_q == GRANT) && (hold_q == HOLD_W'(MAX_HOLD - 1));
  assign timeout_d    = hold_expired & ~rel_normal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q  <= '0;
      timeout <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      timeout <= timeout_d;
    end
  end
`else
  assign hold_expired = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State, pointer and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt     <= '0;
      gnt_idx <= '0;
      gnt_vld <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt     <= gnt_d;
      gnt_idx <= idx_d;
      gnt_vld <= vld_d;
      busy    <= busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = GRANT;
      GRANT:   if (rel)   state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / pointer logic. Outputs are computed one cycle ahead and
  // registered so they switch cleanly with the state. All release causes
  // share the one branch, so the pointer advances exactly once.
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt_d  = gnt;
    idx_d  = gnt_idx;
    vld_d  = gnt_vld;
    busy_d = busy;
    ptr_d  = ptr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          gnt_d  = win_onehot;
          idx_d  = win_idx;
          vld_d  = 1'b1;
          busy_d = 1'b1;
        end else begin
          gnt_d  = '0;
          idx_d  = '0;
          vld_d  = 1'b0;
          busy_d = 1'b0;
        end
      end
      GRANT: begin
        if (rel) begin
          // gnt_idx is kept through RELEASE; it still names the old owner.
          gnt_d  = '0;
          vld_d  = 1'b0;
          busy_d = 1'b1;
          ptr_d  = gnt_idx + 1'b1;
        end
      end
      RELEASE: begin
        gnt_d  = '0;
        idx_d  = '0;
        vld_d  = 1'b0;
        busy_d = 1'b0;
      end
      default: begin
        gnt_d  = '0;
        idx_d  = '0;
        vld_d  = 1'b0;
        busy_d = 1'b0;
      end
    endcase
  end

endmodule
